// File: rtl/proc_control.sv
// Control FSM for the 9-bit bus processor: steps mv/mvi/add/sub/mvnz through T0..T3,
// decodes per-step enables from state and IR, and counts retired instructions.
module proc_control #(
    parameter int N               = 9,
    parameter bit HALT_ON_ILLEGAL = 1'b0,
    parameter int CNT_W           = 16
) (
    input  logic             Clock_i,
    input  logic             Reset_i,
    input  logic             Run_i,
    input  logic [N-1:0]     IR_i,
    input  logic             GNZ_i,
    output logic             IRin_o,
    output logic [7:0]       Rin_o,
    output logic [7:0]       Rout_o,
    output logic             Gout_o,
    output logic             DINout_o,
    output logic             Ain_o,
    output logic             Gin_o,
    output logic             AddSub_o,
    output logic             Done_o,
    output logic             Illegal_o,
    output logic             Halted_o,
    output logic [CNT_W-1:0] InstrCount_o
);

    typedef enum logic [2:0] {T0, T1, T2, T3, HALT} state_t;

    localparam logic [2:0] OP_MV   = 3'b000;
    localparam logic [2:0] OP_MVI  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_MVNZ = 3'b100;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   count_q;

    logic [2:0] opI, opX, opY;
    logic [7:0] xHot, yHot;

    logic       irinDec, goutDec, dinoutDec, ainDec, ginDec, addSubDec;
    logic       doneDec, illegalDec, haltedDec;
    logic [7:0] rinDec, routDec;

    assign opI  = IR_i[8:6];
    assign opX  = IR_i[5:3];
    assign opY  = IR_i[2:0];
    assign xHot = 8'd1 << opX;
    assign yHot = 8'd1 << opY;

    always_comb begin
        state_d    = T0;
        irinDec    = 1'b0;
        rinDec     = 8'd0;
        routDec    = 8'd0;
        goutDec    = 1'b0;
        dinoutDec  = 1'b0;
        ainDec     = 1'b0;
        ginDec     = 1'b0;
        addSubDec  = 1'b0;
        doneDec    = 1'b0;
        illegalDec = 1'b0;
        haltedDec  = 1'b0;
        case (state_q)
            T0: begin
                irinDec = Run_i;
                state_d = Run_i ? T1 : T0;
            end
            T1: begin
                case (opI)
                    OP_MV: begin
                        routDec = yHot;
                        rinDec  = xHot;
                        doneDec = 1'b1;
                    end
                    OP_MVI: begin
                        dinoutDec = 1'b1;
                        rinDec    = xHot;
                        doneDec   = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        routDec = xHot;
                        ainDec  = 1'b1;
                        state_d = T2;
                    end
                    OP_MVNZ: begin
                        doneDec = 1'b1;
                        if (GNZ_i) begin
                            routDec = yHot;
                            rinDec  = xHot;
                        end
                    end
                    default: begin
                        illegalDec = 1'b1;
                        doneDec    = 1'b1;
                        state_d    = HALT_ON_ILLEGAL ? HALT : T0;
                    end
                endcase
            end
            T2: begin
                routDec   = yHot;
                ginDec    = 1'b1;
                addSubDec = (opI == OP_SUB);
                state_d   = T3;
            end
            T3: begin
                goutDec = 1'b1;
                rinDec  = xHot;
                doneDec = 1'b1;
            end
            HALT: begin
                haltedDec = 1'b1;
                state_d   = HALT;
            end
            default: state_d = T0;
        endcase
    end

    // Reset blanks every decoded output in the same cycle, not just from the next edge.
    assign IRin_o       = irinDec    & ~Reset_i;
    assign Rin_o        = rinDec     & {8{~Reset_i}};
    assign Rout_o       = routDec    & {8{~Reset_i}};
    assign Gout_o       = goutDec    & ~Reset_i;
    assign DINout_o     = dinoutDec  & ~Reset_i;
    assign Ain_o        = ainDec     & ~Reset_i;
    assign Gin_o        = ginDec     & ~Reset_i;
    assign AddSub_o     = addSubDec  & ~Reset_i;
    assign Done_o       = doneDec    & ~Reset_i;
    assign Illegal_o    = illegalDec & ~Reset_i;
    assign Halted_o     = haltedDec  & ~Reset_i;
    assign InstrCount_o = count_q;

    always_ff @(posedge Clock_i) begin
        if (Reset_i) begin
            state_q <= T0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            if (doneDec) begin
                count_q <= count_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: tb/tb_proc_control.sv
// Bench for proc_control: directed vector table, halt/wrap sequences on a second
// instance, and random stimulus against a per-instruction step-list model.
module tb_proc_control;

    typedef struct packed {
        logic       irin;
        logic [7:0] rin;
        logic [7:0] rout;
        logic       gout;
        logic       dinout;
        logic       ain;
        logic       gin;
        logic       addSub;
        logic       done;
        logic       illegal;
        logic       halted;
    } outs_t;

    typedef struct {
        logic       rst;
        logic       run;
        logic [8:0] ir;
        logic       gnz;
        outs_t      exp;
        int         cnt;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int nCompared   = 0;
    int nMismatched = 0;

    logic       aRst, aRun, aGnz;
    logic [8:0] aIr;
    logic       aIrin, aGout, aDinout, aAin, aGin, aAddSub, aDone, aIllegal, aHalted;
    logic [7:0] aRin, aRout;
    logic [15:0] aCnt;

    logic       bRst, bRun, bGnz;
    logic [8:0] bIr;
    logic       bIrin, bGout, bDinout, bAin, bGin, bAddSub, bDone, bIllegal, bHalted;
    logic [7:0] bRin, bRout;
    logic [3:0] bCnt;

    proc_control #(.N(9), .HALT_ON_ILLEGAL(1'b0), .CNT_W(16)) dutA (
        .Clock_i(clk), .Reset_i(aRst), .Run_i(aRun), .IR_i(aIr), .GNZ_i(aGnz),
        .IRin_o(aIrin), .Rin_o(aRin), .Rout_o(aRout), .Gout_o(aGout),
        .DINout_o(aDinout), .Ain_o(aAin), .Gin_o(aGin), .AddSub_o(aAddSub),
        .Done_o(aDone), .Illegal_o(aIllegal), .Halted_o(aHalted),
        .InstrCount_o(aCnt)
    );

    proc_control #(.N(9), .HALT_ON_ILLEGAL(1'b1), .CNT_W(4)) dutB (
        .Clock_i(clk), .Reset_i(bRst), .Run_i(bRun), .IR_i(bIr), .GNZ_i(bGnz),
        .IRin_o(bIrin), .Rin_o(bRin), .Rout_o(bRout), .Gout_o(bGout),
        .DINout_o(bDinout), .Ain_o(bAin), .Gin_o(bGin), .AddSub_o(bAddSub),
        .Done_o(bDone), .Illegal_o(bIllegal), .Halted_o(bHalted),
        .InstrCount_o(bCnt)
    );

    outs_t actA, actB;
    assign actA = {aIrin, aRin, aRout, aGout, aDinout, aAin, aGin, aAddSub, aDone, aIllegal, aHalted};
    assign actB = {bIrin, bRin, bRout, bGout, bDinout, bAin, bGin, bAddSub, bDone, bIllegal, bHalted};

    // The shared bus must never see two drivers in the same cycle.
    always @(posedge clk) begin
        assert ($onehot0({aRout, aGout, aDinout}) && $onehot0({bRout, bGout, bDinout}))
            else $error("[TB] bus contention detected");
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic outs_t mk(input logic irin, input logic [7:0] rin, input logic [7:0] rout,
                                 input logic gout, input logic dinout, input logic ain,
                                 input logic gin, input logic addSub, input logic done,
                                 input logic illegal, input logic halted);
        outs_t o;
        o = {irin, rin, rout, gout, dinout, ain, gin, addSub, done, illegal, halted};
        return o;
    endfunction

    // Reference: step 0 is the fetch cycle; steps 1.. walk the instruction's micro-steps.
    function automatic outs_t expectCycle(input logic run, input logic [8:0] ir,
                                          input logic gnz, input int step);
        outs_t      e;
        logic [2:0] op;
        logic [7:0] xh, yh;
        e  = '0;
        op = ir[8:6];
        xh = 8'd1 << ir[5:3];
        yh = 8'd1 << ir[2:0];
        if (step == 0) begin
            e.irin = run;
        end else if (op == 3'd0) begin
            e.rout = yh; e.rin = xh; e.done = 1'b1;
        end else if (op == 3'd1) begin
            e.dinout = 1'b1; e.rin = xh; e.done = 1'b1;
        end else if (op == 3'd2 || op == 3'd3) begin
            if (step == 1) begin
                e.rout = xh; e.ain = 1'b1;
            end else if (step == 2) begin
                e.rout = yh; e.gin = 1'b1; e.addSub = (op == 3'd3);
            end else begin
                e.gout = 1'b1; e.rin = xh; e.done = 1'b1;
            end
        end else if (op == 3'd4) begin
            e.done = 1'b1;
            if (gnz) begin
                e.rout = yh; e.rin = xh;
            end
        end else begin
            e.illegal = 1'b1; e.done = 1'b1;
        end
        return e;
    endfunction

    task automatic applyStimulus(input bit useB, input logic rst, input logic run,
                                 input logic [8:0] ir, input logic gnz);
        @(negedge clk);
        if (useB) begin
            bRst = rst; bRun = run; bIr = ir; bGnz = gnz;
        end else begin
            aRst = rst; aRun = run; aIr = ir; aGnz = gnz;
        end
        #2;
    endtask

    task automatic checkOutput(input bit useB, input string name, input outs_t exp, input int expCnt);
        outs_t act;
        int    actCnt;
        act    = useB ? actB : actA;
        actCnt = useB ? int'(bCnt) : int'(aCnt);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s outputs: got %h expected %h (irin,rin,rout,gout,din,ain,gin,as,done,ill,halt)",
                     name, act, exp);
        end
        nCompared++;
        if (actCnt != expCnt) begin
            nMismatched++;
            $display("[TB] FAIL %s InstrCount: got %0d expected %0d", name, actCnt, expCnt);
        end
        nCompared++;
        if (!$onehot0({act.rout, act.gout, act.dinout}) || !$onehot0(act.rin)) begin
            nMismatched++;
            $display("[TB] FAIL %s one-hot: rin %h rout %h gout %b din %b",
                     name, act.rin, act.rout, act.gout, act.dinout);
        end
    endtask

    vec_t       tbl[$];
    outs_t      zero, fetch, e;
    logic [8:0] rIr;
    logic       rRst, rRun, rGnz;
    int         mStep, mCount;

    function automatic vec_t vec(input logic rst, input logic run, input logic [8:0] ir,
                                 input logic gnz, input outs_t exp, input int cnt);
        vec_t v;
        v.rst = rst; v.run = run; v.ir = ir; v.gnz = gnz; v.exp = exp; v.cnt = cnt;
        return v;
    endfunction

    initial begin
        aRst = 1'b1; aRun = 1'b0; aIr = '0; aGnz = 1'b0;
        bRst = 1'b1; bRun = 1'b0; bIr = '0; bGnz = 1'b0;
        zero  = '0;
        fetch = mk(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0);

        tbl.push_back(vec(1, 1, 9'b001_010_000, 0, zero, 0));
        tbl.push_back(vec(0, 1, 9'b001_010_000, 0, fetch, 0));
        tbl.push_back(vec(0, 0, 9'b001_010_000, 0, mk(0, 8'h04, 8'h00, 0, 1, 0, 0, 0, 1, 0, 0), 0));
        tbl.push_back(vec(0, 0, 9'b001_010_000, 0, zero, 1));
        tbl.push_back(vec(0, 1, 9'b010_001_011, 0, fetch, 1));
        tbl.push_back(vec(0, 1, 9'b010_001_011, 0, mk(0, 8'h00, 8'h02, 0, 0, 1, 0, 0, 0, 0, 0), 1));
        tbl.push_back(vec(0, 1, 9'b010_001_011, 0, mk(0, 8'h00, 8'h08, 0, 0, 0, 1, 0, 0, 0, 0), 1));
        tbl.push_back(vec(0, 1, 9'b010_001_011, 0, mk(0, 8'h02, 8'h00, 1, 0, 0, 0, 0, 1, 0, 0), 1));
        tbl.push_back(vec(0, 1, 9'b011_001_011, 0, fetch, 2));
        tbl.push_back(vec(0, 1, 9'b011_001_011, 0, mk(0, 8'h00, 8'h02, 0, 0, 1, 0, 0, 0, 0, 0), 2));
        tbl.push_back(vec(0, 1, 9'b011_001_011, 0, mk(0, 8'h00, 8'h08, 0, 0, 0, 1, 1, 0, 0, 0), 2));
        tbl.push_back(vec(0, 1, 9'b011_001_011, 0, mk(0, 8'h02, 8'h00, 1, 0, 0, 0, 0, 1, 0, 0), 2));
        tbl.push_back(vec(0, 1, 9'b100_100_101, 0, fetch, 3));
        tbl.push_back(vec(0, 0, 9'b100_100_101, 0, mk(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 1, 0, 0), 3));
        tbl.push_back(vec(0, 1, 9'b100_100_101, 1, fetch, 4));
        tbl.push_back(vec(0, 0, 9'b100_100_101, 1, mk(0, 8'h10, 8'h20, 0, 0, 0, 0, 0, 1, 0, 0), 4));
        tbl.push_back(vec(0, 1, 9'b110_000_000, 0, fetch, 5));
        tbl.push_back(vec(0, 0, 9'b110_000_000, 0, mk(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 1, 1, 0), 5));
        tbl.push_back(vec(0, 0, 9'b110_000_000, 0, zero, 6));
        tbl.push_back(vec(0, 1, 9'b011_010_001, 0, fetch, 6));
        tbl.push_back(vec(0, 0, 9'b011_010_001, 0, mk(0, 8'h00, 8'h04, 0, 0, 1, 0, 0, 0, 0, 0), 6));
        tbl.push_back(vec(1, 0, 9'b011_010_001, 0, zero, 6));
        tbl.push_back(vec(0, 0, 9'b011_010_001, 0, zero, 0));
        tbl.push_back(vec(0, 1, 9'b011_010_001, 0, fetch, 0));
        tbl.push_back(vec(0, 0, 9'b011_010_001, 0, mk(0, 8'h00, 8'h04, 0, 0, 1, 0, 0, 0, 0, 0), 0));
        tbl.push_back(vec(0, 0, 9'b011_010_001, 0, mk(0, 8'h00, 8'h02, 0, 0, 0, 1, 1, 0, 0, 0), 0));
        tbl.push_back(vec(0, 0, 9'b011_010_001, 0, mk(0, 8'h04, 8'h00, 1, 0, 0, 0, 0, 1, 0, 0), 0));
        tbl.push_back(vec(0, 0, 9'b011_010_001, 0, zero, 1));
        tbl.push_back(vec(0, 1, 9'b000_011_011, 0, fetch, 1));
        tbl.push_back(vec(0, 0, 9'b000_011_011, 0, mk(0, 8'h08, 8'h08, 0, 0, 0, 0, 0, 1, 0, 0), 1));
        tbl.push_back(vec(0, 0, 9'b000_011_011, 0, zero, 2));

        applyStimulus(0, 1, 0, 9'd0, 0);
        for (int i = 0; i < tbl.size(); i++) begin
            applyStimulus(0, tbl[i].rst, tbl[i].run, tbl[i].ir, tbl[i].gnz);
            checkOutput(0, $sformatf("table[%0d]", i), tbl[i].exp, tbl[i].cnt);
        end

        // Halting instance: illegal opcode parks it until reset, ignoring Run.
        applyStimulus(1, 1, 1, 9'd0, 0);
        applyStimulus(1, 0, 1, 9'b110_000_000, 0);
        checkOutput(1, "halt_fetch", fetch, 0);
        applyStimulus(1, 0, 1, 9'b110_000_000, 0);
        checkOutput(1, "halt_illegal", mk(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 1, 1, 0), 0);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1, 0, 1, 9'b001_001_001, 0);
            checkOutput(1, "halt_parked", mk(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0, 1), 1);
        end
        applyStimulus(1, 1, 1, 9'b001_001_001, 0);
        checkOutput(1, "halt_reset", zero, 1);
        applyStimulus(1, 0, 0, 9'b001_001_001, 0);
        checkOutput(1, "halt_exit", zero, 0);
        applyStimulus(1, 0, 1, 9'b001_001_001, 0);
        checkOutput(1, "halt_refetch", fetch, 0);

        // Four-bit counter wraps after sixteen retirements.
        applyStimulus(1, 1, 0, 9'd0, 0);
        for (int k = 0; k < 17; k++) begin
            applyStimulus(1, 0, 1, 9'b000_001_010, 0);
            checkOutput(1, "wrap_fetch", fetch, k % 16);
            applyStimulus(1, 0, 1, 9'b000_001_010, 0);
            checkOutput(1, "wrap_mv", mk(0, 8'h02, 8'h04, 0, 0, 0, 0, 0, 1, 0, 0), k % 16);
        end
        applyStimulus(1, 0, 0, 9'b000_001_010, 0);
        checkOutput(1, "wrap_final", zero, 1);

        // Random opcodes, Run, GNZ and occasional resets against the reference model.
        applyStimulus(0, 1, 0, 9'd0, 0);
        mStep  = 0;
        mCount = 0;
        rIr    = '0;
        for (int i = 0; i < 3000; i++) begin
            rRst = ($urandom_range(0, 59) == 0);
            rRun = ($urandom_range(0, 3) != 0);
            if (mStep == 0) rIr = 9'($urandom);
            rGnz = 1'($urandom_range(0, 1));
            applyStimulus(0, rRst, rRun, rIr, rGnz);
            e = rRst ? zero : expectCycle(rRun, rIr, rGnz, mStep);
            checkOutput(0, "random", e, mCount);
            if (rRst) begin
                mStep  = 0;
                mCount = 0;
            end else if (e.done) begin
                mStep  = 0;
                mCount = (mCount + 1) & 16'hFFFF;
            end else if (mStep == 0) begin
                mStep = rRun ? 1 : 0;
            end else begin
                mStep++;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
